bp_fe_icache_mem_responder: RTL and testbench

//  Memory-side responder for the I$/UCE fill path. Consumes mem_cmd
//  (block/uncached reads and writes) and returns mem_resp after a fixed

---
 rtl/bp_fe_icache_mem_responder_if.sv | 29 ++
 rtl/bp_fe_icache_mem_responder.sv | 152 +++++++++++++++
 tb/tb_bp_fe_icache_mem_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_fe_icache_mem_responder_if.sv
// Command/response channel between an I$/UCE fill requester and a memory responder.
interface bp_fe_icache_mem_responder_if #(
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned block_width_p = 512
) ();
  logic                     cmd_v;
  logic                     cmd_ready;
  logic [1:0]               cmd_opcode;
  logic [paddr_width_p-1:0] cmd_addr;
  logic [2:0]               cmd_size;
  logic [block_width_p-1:0] cmd_data;

  logic                     resp_v;
  logic                     resp_yumi;
  logic [1:0]               resp_opcode;
  logic [paddr_width_p-1:0] resp_addr;
  logic [2:0]               resp_size;
  logic [block_width_p-1:0] resp_data;

  modport master (
    output cmd_v, cmd_opcode, cmd_addr, cmd_size, cmd_data, resp_yumi,
    input  cmd_ready, resp_v, resp_opcode, resp_addr, resp_size, resp_data
  );

  modport slave (
    input  cmd_v, cmd_opcode, cmd_addr, cmd_size, cmd_data, resp_yumi,
    output cmd_ready, resp_v, resp_opcode, resp_addr, resp_size, resp_data
  );
endinterface

// File: rtl/bp_fe_icache_mem_responder.sv
// Fixed-latency, single-outstanding memory responder backed by a block-organised store.
module bp_fe_icache_mem_responder #(
  parameter int unsigned              paddr_width_p = 40,
  parameter int unsigned              block_width_p = 512,
  parameter int unsigned              els_p         = 256,
  parameter int unsigned              latency_p     = 4,
  parameter logic [paddr_width_p-1:0] mem_offset_p  = 'h8000_0000
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  bp_fe_icache_mem_responder_if.slave mem,
  output logic                        error_o
);
  localparam int unsigned BlockBytes = block_width_p / 8;
  localparam int unsigned BoffW      = $clog2(BlockBytes);
  localparam int unsigned IdxW       = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned CntW       = (latency_p > 0) ? $clog2(latency_p + 1) : 1;
  localparam logic [paddr_width_p:0] Base  = {1'b0, mem_offset_p};
  localparam logic [paddr_width_p:0] Limit = Base + (paddr_width_p + 1)'(els_p * BlockBytes);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     live_q;
  logic [1:0]               opcode_q;
  logic [paddr_width_p-1:0] addr_q;
  logic [2:0]               size_q;
  logic [block_width_p-1:0] wdata_q, rdata_q, rdata_d;
  logic                     error_q;

  logic [block_width_p-1:0] mem_q [els_p];

  logic                     accept, access, in_range;
  logic [paddr_width_p-1:0] rel;
  logic [IdxW-1:0]          idx;
  logic [BoffW-1:0]         byte_off, lane_mask, aligned;
  logic [2:0]               eff_size;
  logic [block_width_p-1:0] blk, uc_rd, uc_wr;
  logic                     unused_rel;

  // live_q keeps ready low for the first cycle after reset release
  assign mem.cmd_ready = (state_q == StIdle) && live_q;
  assign accept        = mem.cmd_ready && mem.cmd_v;
  assign access        = (state_q == StWait) && (cnt_q == '0);

  assign mem.resp_v      = (state_q == StResp);
  assign mem.resp_opcode = opcode_q;
  assign mem.resp_addr   = addr_q;
  assign mem.resp_size   = size_q;
  assign mem.resp_data   = rdata_q;
  assign error_o         = error_q;

  assign rel        = addr_q - mem_offset_p;
  assign idx        = rel[BoffW +: IdxW];
  assign byte_off   = rel[BoffW-1:0];
  assign in_range   = ({1'b0, addr_q} >= Base) && ({1'b0, addr_q} < Limit);
  assign unused_rel = ^rel;
  assign blk        = mem_q[idx];

  // Next state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          cnt_d   = CntW'(latency_p);
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StResp;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StResp: begin
        if (mem.resp_yumi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Clamp size to a block and derive the aligned byte lane window
  always_comb begin
    eff_size  = size_q;
    lane_mask = '0;
    if (size_q > 3'(BoffW)) eff_size = 3'(BoffW);
    for (int i = 0; i < BoffW; i++) lane_mask[i] = (i < int'(eff_size));
    aligned = byte_off & ~lane_mask;
  end

  // Uncached read replicates the window; uncached write merges it into the block
  always_comb begin
    uc_rd = '0;
    uc_wr = blk;
    for (int b = 0; b < BlockBytes; b++) begin
      uc_rd[8*b +: 8] = blk[{aligned | (BoffW'(b) & lane_mask), 3'b000} +: 8];
      if ((BoffW'(b) & ~lane_mask) == aligned) begin
        uc_wr[8*b +: 8] = wdata_q[{BoffW'(b) & lane_mask, 3'b000} +: 8];
      end
    end
  end

  // Read data returned with the response; writes and out-of-range return zero
  always_comb begin
    rdata_d = '0;
    if (in_range) begin
      case (opcode_q)
        2'd0:    rdata_d = blk;
        2'd2:    rdata_d = uc_rd;
        default: rdata_d = '0;
      endcase
    end
  end

  // Backing store, intentionally not reset
  always_ff @(posedge clk_i) begin
    if (access && in_range) begin
      if (opcode_q == 2'd1)      mem_q[idx] <= wdata_q;
      else if (opcode_q == 2'd3) mem_q[idx] <= uc_wr;
    end
  end

  // Control state, latched command and response registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      live_q   <= 1'b0;
      opcode_q <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      if (accept) begin
        opcode_q <= mem.cmd_opcode;
        addr_q   <= mem.cmd_addr;
        size_q   <= mem.cmd_size;
        wdata_q  <= mem.cmd_data;
      end
      if (access) begin
        rdata_q <= rdata_d;
        if (!in_range) error_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bp_fe_icache_mem_responder.sv
// Randomized bench with a byte-array reference model for the memory responder.
module tb_bp_fe_icache_mem_responder;
  localparam int unsigned     Lat  = 4;
  localparam longint unsigned Base = 64'h8000_0000;
  localparam int unsigned     Nb   = 256 * 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err, err0;
  always #5 clk = ~clk;

  bp_fe_icache_mem_responder_if #(.paddr_width_p(40), .block_width_p(512)) mif ();
  bp_fe_icache_mem_responder_if #(.paddr_width_p(40), .block_width_p(512)) mif0 ();

  bp_fe_icache_mem_responder #(.latency_p(Lat)) u_dut (
    .clk_i(clk), .reset_n_i(reset_n), .mem(mif), .error_o(err)
  );
  bp_fe_icache_mem_responder #(.latency_p(0)) u_dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .mem(mif0), .error_o(err0)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]   model_mem [Nb];
  logic [1:0]   exp_op;
  logic [39:0]  exp_addr;
  logic [2:0]   exp_size;
  logic [511:0] exp_data;
  logic         exp_err = 1'b0;
  logic [511:0] last_data;

  // Reference: byte-addressed store, applied at accept time
  task automatic model_access(input logic [1:0] op, input logic [39:0] addr,
                              input logic [2:0] size, input logic [511:0] data,
                              output logic [511:0] r);
    longint unsigned a, rel, n, blk, al;
    r = '0;
    a = 64'(addr);
    if (a < Base || a >= Base + Nb) begin
      exp_err = 1'b1;
      return;
    end
    rel = a - Base;
    n   = 64'd1 << ((size > 3'd6) ? 6 : int'(size));
    blk = (rel / 64) * 64;
    al  = (rel / n) * n;
    case (op)
      2'd0: for (int i = 0; i < 64; i++) r[8*i +: 8] = model_mem[int'(blk) + i];
      2'd1: for (int i = 0; i < 64; i++) model_mem[int'(blk) + i] = data[8*i +: 8];
      2'd2: for (int i = 0; i < 64; i++) r[8*i +: 8] = model_mem[int'(al) + (i % int'(n))];
      default: for (int i = 0; i < int'(n); i++) model_mem[int'(al) + i] = data[8*i +: 8];
    endcase
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [1:0] op, input logic [39:0] addr, input logic [2:0] size,
                      input logic [511:0] data, input bit keep);
    int w = 0;
    mif.cmd_opcode = op;
    mif.cmd_addr   = addr;
    mif.cmd_size   = size;
    mif.cmd_data   = data;
    mif.cmd_v      = 1'b1;
    while (mif.cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("accept_timeout", 512'(w < 50), 512'(1));
    exp_op   = op;
    exp_addr = addr;
    exp_size = size;
    model_access(op, addr, size, data, exp_data);
    @(negedge clk);
    if (!keep) mif.cmd_v = 1'b0;
  endtask

  task automatic check_resp(input string tag);
    check({tag, "_v"},      512'(mif.resp_v),      512'(1));
    check({tag, "_opcode"}, 512'(mif.resp_opcode), 512'(exp_op));
    check({tag, "_addr"},   512'(mif.resp_addr),   512'(exp_addr));
    check({tag, "_size"},   512'(mif.resp_size),   512'(exp_size));
    check({tag, "_data"},   mif.resp_data,         exp_data);
    check({tag, "_ready"},  512'(mif.cmd_ready),   512'(0));
  endtask

  task automatic collect(input int hold);
    int lat = 1;
    while (mif.resp_v !== 1'b1 && lat < 60) begin
      check("ready_in_flight", 512'(mif.cmd_ready), 512'(0));
      @(negedge clk);
      lat++;
    end
    check("resp_latency", 512'(lat), 512'(Lat + 2));
    check_resp("resp");
    check("error", 512'(err), 512'(exp_err));
    last_data = mif.resp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_resp("stall");
    end
    mif.resp_yumi = 1'b1;
    @(negedge clk);
    mif.resp_yumi = 1'b0;
    check("ready_after_yumi", 512'(mif.cmd_ready), 512'(1));
    check("resp_v_after_yumi", 512'(mif.resp_v), 512'(0));
  endtask

  initial begin
    logic [511:0] pat, pre;
    logic [39:0]  a;
    int           seen;

    mif.cmd_v = 0; mif.cmd_opcode = 0; mif.cmd_addr = 0; mif.cmd_size = 0;
    mif.cmd_data = 0; mif.resp_yumi = 0;
    mif0.cmd_v = 0; mif0.cmd_opcode = 0; mif0.cmd_addr = 0; mif0.cmd_size = 0;
    mif0.cmd_data = 0; mif0.resp_yumi = 0;

    // Reset state
    #1;
    check("rst_ready", 512'(mif.cmd_ready), 512'(0));
    check("rst_resp_v", 512'(mif.resp_v), 512'(0));
    check("rst_error", 512'(err), 512'(0));
    check("rst_resp_data", mif.resp_data, 512'(0));
    check("rst_resp_addr", 512'(mif.resp_addr), 512'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 512'(mif.cmd_ready), 512'(1));

    // Reset mid-WAIT drops the transaction
    send(2'd0, 40'(Base), 3'd6, '0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_resp_v", 512'(mif.resp_v), 512'(0));
    check("midrst_ready", 512'(mif.cmd_ready), 512'(0));
    check("midrst_resp_addr", 512'(mif.resp_addr), 512'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", 512'(mif.cmd_ready), 512'(1));
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (mif.resp_v === 1'b1) seen++;
      @(negedge clk);
    end
    check("midrst_stale_resp", 512'(seen), 512'(0));

    // Fill every block with random data
    for (int b = 0; b < 256; b++) begin
      send(2'd1, 40'(Base + 64'(b) * 64), 3'd6, rand_block(), 1'b0);
      collect(0);
    end

    // Block write then block read of block 0
    for (int i = 0; i < 32; i++) pat[16*i +: 16] = 16'(i * 16'h0101);
    send(2'd1, 40'h80_0000_0000 >> 8, 3'd6, pat, 1'b0);
    collect(0);
    send(2'd0, 40'(Base), 3'd6, '0, 1'b0);
    collect(2);
    check("blk0_readback", last_data, pat);

    // Uncached word write into block 1 and readback
    send(2'd0, 40'(Base + 64), 3'd6, '0, 1'b0);
    collect(0);
    pre = last_data;
    send(2'd3, 40'(Base + 'h44), 3'd2, 512'h0000_0000_DEAD_BEEF, 1'b0);
    collect(0);
    send(2'd2, 40'(Base + 'h44), 3'd2, '0, 1'b0);
    collect(0);
    check("uc_rd_replicated", last_data, {16{32'hDEAD_BEEF}});
    send(2'd0, 40'(Base + 'h40), 3'd6, '0, 1'b0);
    collect(0);
    check("uc_wr_bytes4_7", 512'(last_data[63:32]), 512'(32'hDEAD_BEEF));
    check("uc_wr_others", {last_data[511:64], last_data[31:0]}, {pre[511:64], pre[31:0]});

    // Backpressure with a second command held valid
    send(2'd0, 40'(Base + 'h80), 3'd6, '0, 1'b1);
    mif.cmd_addr = 40'(Base + 'hC0);
    collect(10);
    send(2'd0, 40'(Base + 'hC0), 3'd6, '0, 1'b0);
    collect(0);

    // Out of range, then sticky error through a good read
    send(2'd0, 40'h7F_FFFF_FFC0 >> 8, 3'd6, '0, 1'b0);
    collect(0);
    check("oor_data", last_data, 512'(0));
    check("oor_error", 512'(err), 512'(1));
    send(2'd0, 40'(Base + 'h100), 3'd6, '0, 1'b0);
    collect(0);

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0) a = 40'(Base - 64'($urandom_range(1, 4096)));
        else                           a = 40'(Base + Nb + 64'($urandom_range(0, 4096)));
      end else begin
        a = 40'(Base + 64'($urandom_range(0, Nb - 1)));
      end
      send(2'($urandom_range(0, 3)), a, 3'($urandom_range(0, 6)), rand_block(), 1'b0);
      collect(int'($urandom_range(0, 3)));
    end

    // Zero-latency instance: back-to-back reads, one response every 3 cycles
    mif0.cmd_opcode = 2'd0;
    mif0.cmd_addr   = 40'(Base + 'h200);
    mif0.cmd_size   = 3'd6;
    mif0.cmd_v      = 1'b1;
    mif0.resp_yumi  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      check("lat0_resp_v", 512'(mif0.resp_v), 512'((i % 3) == 2));
      if ((i % 3) == 2) check("lat0_resp_addr", 512'(mif0.resp_addr), 512'(Base + 'h200));
      @(negedge clk);
    end
    mif0.cmd_v     = 1'b0;
    mif0.resp_yumi = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
